fedp_seq_ctrl: RTL and testbench

FEDP_SEQ_CTRL -- requirements
Module: fedp_seq_ctrl

---
 rtl/fedp_seq_ctrl_if.sv | 41 ++++
 rtl/fedp_seq_ctrl.sv | 106 ++++++++++
 tb/tb_fedp_seq_ctrl.sv | 249 ++++++++++++++++++++++++
 3 files changed

// File: rtl/fedp_seq_ctrl_if.sv
// Handshake and datapath bundle between the dot-product sequencer and its surroundings.
// The slave side is the sequencer; the master side is the job source, operand feed and FEDP unit.
interface fedp_seq_ctrl_if;
  logic        start;
  logic [7:0]  len;
  logic [15:0] bias;
  logic        abort;

  logic        op_valid;
  logic        op_ready;
  logic [31:0] op_w;
  logic [31:0] op_a;

  logic [7:0]  fedp_w0;
  logic [7:0]  fedp_w1;
  logic [7:0]  fedp_w2;
  logic [7:0]  fedp_w3;
  logic [7:0]  fedp_a0;
  logic [7:0]  fedp_a1;
  logic [7:0]  fedp_a2;
  logic [7:0]  fedp_a3;
  logic [15:0] fedp_psum;
  logic [15:0] fedp_result;

  logic        busy;
  logic        out_valid;
  logic        out_ready;
  logic [15:0] out_data;

  modport slave (
    input  start, len, bias, abort, op_valid, op_w, op_a, fedp_result, out_ready,
    output op_ready, fedp_w0, fedp_w1, fedp_w2, fedp_w3,
           fedp_a0, fedp_a1, fedp_a2, fedp_a3, fedp_psum, busy, out_valid, out_data
  );

  modport master (
    output start, len, bias, abort, op_valid, op_w, op_a, fedp_result, out_ready,
    input  op_ready, fedp_w0, fedp_w1, fedp_w2, fedp_w3,
           fedp_a0, fedp_a1, fedp_a2, fedp_a3, fedp_psum, busy, out_valid, out_data
  );
endinterface

// File: rtl/fedp_seq_ctrl.sv
// Sequencer feeding 4-lane operand groups into a 2-cycle dot-product unit and accumulating
// the returned products onto a signed bias; one job of len groups at a time.
module fedp_seq_ctrl (
  input  logic            clk,
  input  logic            rst,
  fedp_seq_ctrl_if.slave  bus
);

  typedef enum logic [1:0] {StIdle, StRun, StDrain, StDone} state_e;

  state_e      state_q, state_d;
  logic [7:0]  len_q, len_d;
  logic [7:0]  issued_q, issued_d;
  logic [7:0]  retired_q, retired_d;
  logic [15:0] acc_q, acc_d;
  logic [1:0]  vld_q, vld_d;
  logic        fire;

  assign bus.op_ready = (state_q == StRun) && (issued_q < len_q);
  assign fire         = bus.op_valid && bus.op_ready;

  // Operands are gated so the unit only ever sees real groups; idle cycles present zeros.
  assign bus.fedp_w0   = fire ? bus.op_w[7:0]   : 8'd0;
  assign bus.fedp_w1   = fire ? bus.op_w[15:8]  : 8'd0;
  assign bus.fedp_w2   = fire ? bus.op_w[23:16] : 8'd0;
  assign bus.fedp_w3   = fire ? bus.op_w[31:24] : 8'd0;
  assign bus.fedp_a0   = fire ? bus.op_a[7:0]   : 8'd0;
  assign bus.fedp_a1   = fire ? bus.op_a[15:8]  : 8'd0;
  assign bus.fedp_a2   = fire ? bus.op_a[23:16] : 8'd0;
  assign bus.fedp_a3   = fire ? bus.op_a[31:24] : 8'd0;
  assign bus.fedp_psum = 16'd0;

  assign bus.busy      = (state_q != StIdle);
  assign bus.out_valid = (state_q == StDone);
  assign bus.out_data  = (state_q == StDone) ? acc_q : 16'd0;

  always_comb begin
    state_d   = state_q;
    len_d     = len_q;
    issued_d  = issued_q;
    retired_d = retired_q;
    acc_d     = acc_q;
    vld_d     = {vld_q[0], fire};

    // vld_q[1] marks the cycle in which a fired group's product is on fedp_result.
    if (vld_q[1]) begin
      acc_d     = acc_q + bus.fedp_result;
      retired_d = retired_q + 8'd1;
    end
    if (fire) begin
      issued_d = issued_q + 8'd1;
    end

    unique case (state_q)
      StIdle: begin
        if (bus.start) begin
          len_d     = bus.len;
          acc_d     = bus.bias;
          issued_d  = 8'd0;
          retired_d = 8'd0;
          state_d   = (bus.len != 8'd0) ? StRun : StDone;
        end
      end
      StRun: begin
        if (fire && ((issued_q + 8'd1) == len_q)) begin
          state_d = StDrain;
        end
      end
      StDrain: begin
        if (retired_q == len_q) begin
          state_d = StDone;
        end
      end
      StDone: begin
        if (bus.out_ready) begin
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase

    if (bus.abort && (state_q != StIdle)) begin
      state_d = StIdle;
      vld_d   = 2'b00;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= StIdle;
      len_q     <= 8'd0;
      issued_q  <= 8'd0;
      retired_q <= 8'd0;
      acc_q     <= 16'd0;
      vld_q     <= 2'b00;
    end else begin
      state_q   <= state_d;
      len_q     <= len_d;
      issued_q  <= issued_d;
      retired_q <= retired_d;
      acc_q     <= acc_d;
      vld_q     <= vld_d;
    end
  end

endmodule

// File: tb/tb_fedp_seq_ctrl.sv
// Scoreboard bench for fedp_seq_ctrl: directed corner jobs plus randomized jobs, with an
// environment model of the 2-cycle dot-product unit and a queue of expected job results.
module tb_fedp_seq_ctrl;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   cyc = 0;

  fedp_seq_ctrl_if bus ();

  fedp_seq_ctrl dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  int          checks = 0;
  int          failures = 0;
  int          fires = 0;
  int          op_ready_cycles = 0;
  logic [15:0] exp_q[$];
  logic [31:0] gw[$];
  logic [31:0] ga[$];
  bit          prev_held = 1'b0;
  logic [15:0] prev_data = 16'd0;

  task automatic check(input string name, input logic [95:0] act, input logic [95:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic logic [15:0] dot4(input logic [31:0] w, input logic [31:0] a);
    int sum;
    sum = 0;
    for (int i = 0; i < 4; i++) begin
      sum += int'($signed(w[8*i +: 8])) * int'($signed(a[8*i +: 8]));
    end
    return sum[15:0];
  endfunction

  // Dot-product unit model: operands in cycle c, 16-bit wrapped product visible in cycle c+2.
  logic [15:0] p1 = 16'd0;
  logic [15:0] p2 = 16'd0;
  always @(posedge clk) begin
    p1 <= dot4({bus.fedp_w3, bus.fedp_w2, bus.fedp_w1, bus.fedp_w0},
               {bus.fedp_a3, bus.fedp_a2, bus.fedp_a1, bus.fedp_a0});
    p2 <= p1;
  end
  assign bus.fedp_result = p2;

  // Monitor: operand routing, result hold stability, and scoreboard pops on acceptance.
  always @(negedge clk) begin
    if (!rst) begin
      if (bus.op_ready) op_ready_cycles++;
      if (bus.op_valid && bus.op_ready) begin
        fires++;
        check("fedp_ops", {bus.fedp_psum, bus.fedp_w3, bus.fedp_w2, bus.fedp_w1, bus.fedp_w0,
                           bus.fedp_a3, bus.fedp_a2, bus.fedp_a1, bus.fedp_a0},
              {16'd0, bus.op_w, bus.op_a});
      end else begin
        check("fedp_idle_zero", {bus.fedp_psum, bus.fedp_w3, bus.fedp_w2, bus.fedp_w1,
                                 bus.fedp_w0, bus.fedp_a3, bus.fedp_a2, bus.fedp_a1,
                                 bus.fedp_a0}, 96'd0);
      end
      if (prev_held) check("out_hold", {bus.out_valid, bus.out_data}, {1'b1, prev_data});
      if (bus.out_valid && bus.out_ready) begin
        check("out_expected", exp_q.size() != 0, 1);
        if (exp_q.size() != 0) check("out_data", bus.out_data, exp_q.pop_front());
      end
      prev_held = bus.out_valid && !bus.out_ready;
      prev_data = bus.out_data;
    end else begin
      prev_held = 1'b0;
    end
  end

  // mode 0: normal job, 1: abort once in DRAIN, 2: reset after three fires.
  task automatic run_job(input int n, input logic [15:0] b, input int gap, input int hold,
                         input int mode);
    int          s, idx, budget, lat;
    logic [15:0] acc;
    bit          seen;
    while (gw.size() < n) begin
      gw.push_back($urandom);
      ga.push_back($urandom);
    end
    acc = b;
    for (int i = 0; i < n; i++) acc += dot4(gw[i], ga[i]);
    if (mode == 0) exp_q.push_back(acc);
    fires = 0;
    op_ready_cycles = 0;

    @(posedge clk); #1;
    bus.start = 1'b1;
    bus.len   = n[7:0];
    bus.bias  = b;
    bus.abort = (gap == 2) ? 1'($urandom_range(0, 1)) : 1'b0;
    s = cyc;
    @(posedge clk); #1;
    bus.start = 1'b0;
    bus.abort = 1'b0;

    idx = 0;
    budget = 3 * n + 20;
    while (idx < n && budget > 0) begin
      budget--;
      if (mode == 2 && idx == 3) break;
      if (gap == 0)      bus.op_valid = 1'b1;
      else if (gap == 1) bus.op_valid = (cyc % 2 == 0);
      else               bus.op_valid = ($urandom_range(0, 2) != 0);
      bus.op_w = bus.op_valid ? gw[idx] : $urandom;
      bus.op_a = bus.op_valid ? ga[idx] : $urandom;
      if (gap == 2) begin
        bus.start = ($urandom_range(0, 3) == 0);
        bus.len   = 8'($urandom);
      end
      @(negedge clk);
      if (bus.op_valid && bus.op_ready) idx++;
      @(posedge clk); #1;
    end
    bus.start = 1'b0;

    if (mode == 2) begin
      bus.op_valid = 1'b1;
      bus.start    = 1'b1;
      bus.abort    = 1'b1;
      rst          = 1'b1;
      @(posedge clk); #1;
      rst       = 1'b0;
      bus.start = 1'b0;
      bus.abort = 1'b0;
      @(negedge clk);
      check("reset_midrun_outputs", {bus.op_ready, bus.busy, bus.out_valid, bus.out_data},
            96'd0);
      bus.op_valid = 1'b0;
      gw.delete();
      ga.delete();
      return;
    end

    bus.op_valid = 1'b0;
    check("issue_count", idx, n);

    if (mode == 1) begin
      bus.abort = 1'b1;
      @(negedge clk);
      check("drain_busy", bus.busy, 1);
      @(posedge clk); #1;
      bus.abort = 1'b0;
      @(negedge clk);
      check("abort_idle", bus.busy, 0);
      seen = bus.out_valid;
      repeat (8) begin
        @(negedge clk);
        seen |= bus.out_valid;
      end
      check("abort_no_valid", seen, 0);
      gw.delete();
      ga.delete();
      return;
    end

    seen = 1'b0;
    budget = 60;
    while (!seen && budget > 0) begin
      @(negedge clk);
      budget--;
      if (bus.out_valid) seen = 1'b1;
    end
    lat = cyc - s;
    check("out_valid_timeout", seen, 1);
    if (gap == 0) check("latency", lat, (n == 0) ? 1 : n + 4);
    if (n == 0) check("len0_no_ready", op_ready_cycles, 0);
    check("done_busy", bus.busy, 1);

    repeat (hold) @(posedge clk);
    @(posedge clk); #1;
    bus.out_ready = 1'b1;
    @(posedge clk); #1;
    bus.out_ready = 1'b0;
    @(negedge clk);
    check("post_accept_idle", {bus.busy, bus.out_valid}, 0);
    check("fire_count", fires, n);
    gw.delete();
    ga.delete();
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    bus.start     = 1'b0;
    bus.len       = 8'd0;
    bus.bias      = 16'd0;
    bus.abort     = 1'b0;
    bus.op_valid  = 1'b0;
    bus.op_w      = 32'd0;
    bus.op_a      = 32'd0;
    bus.out_ready = 1'b0;

    repeat (3) @(posedge clk);
    @(negedge clk);
    check("reset_outputs", {bus.op_ready, bus.busy, bus.out_valid, bus.out_data}, 96'd0);
    @(posedge clk); #1;
    rst = 1'b0;

    // Single group, bias 5: 1+2+3+4 onto 5.
    gw.push_back(32'h04030201);
    ga.push_back(32'h01010101);
    run_job(1, 16'd5, 0, 0, 0);

    // Extreme negative lanes: each group's 65536 wraps to zero.
    repeat (3) begin
      gw.push_back(32'h80808080);
      ga.push_back(32'h80808080);
    end
    run_job(3, 16'd0, 0, 0, 0);

    run_job(0, -16'sd7, 0, 0, 0);
    run_job(4, 16'h1234, 1, 3, 0);
    run_job(2, 16'd9, 0, 0, 1);
    gw.push_back(32'h7f7f7f7f);
    ga.push_back(32'h81818181);
    run_job(1, 16'h0100, 0, 0, 0);
    run_job(8, 16'd3, 0, 0, 2);
    run_job(5, 16'hfff0, 0, 1, 0);

    for (int j = 0; j < 24; j++) begin
      n = (j % 7 == 6) ? $urandom_range(30, 60) : $urandom_range(0, 12);
      run_job(n, 16'($urandom), (j % 3 == 0) ? 0 : 2, $urandom_range(0, 3), 0);
    end

    repeat (4) @(posedge clk);
    check("scoreboard_empty", exp_q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
